uart_rx_oversampled: RTL and testbench

Oversampling UART receiver: the receive end of the team's 8-bit UART link, accepting frames produced by the existing transmitter (start, 8 data bits LSB-first, one parity bit, 1 or 2 stop bits). It samples the serial line at 16x the bit rate, validates start, parity and stop bits, and presents each byte with a one-cycle valid strobe. It sits between the pad-side serial input and the byte-level consumer, sharing `baud_divisor`, `parity_sel` and `stop_sel` semantics with the transmitter.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_rx_oversampled_if.sv | 60 ++++++
 rtl/uart_baud_tick.sv | 48 ++++
 rtl/uart_rx_oversampled.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8-bit UART link. The transmitter and the
// oversampling receiver both import this package. That way the bit timing,
// the data width and the receiver state names are defined in one place.
//
// Contents:
//   OVERSAMPLE   sample ticks per serial bit
//   MID_SAMPLE   centre sample index inside a bit
//   DATA_W       payload width of one frame
//   SAMPLE_W     width of the per-bit sample counter
//   SAMPLE_*     sample indices used by the receiver (vote window, bit end)
//   rx_state_t   receiver frame states
//   majority3    2-of-3 vote used to de-glitch the mid-bit samples
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_W     = 8;
  localparam int SAMPLE_W   = $clog2(OVERSAMPLE);

  // The vote window straddles the bit centre: one sample before it, the
  // centre sample itself, and one sample after it. The decision falls on the
  // late sample, so everything that depends on a bit value happens there.
  localparam logic [SAMPLE_W-1:0] SAMPLE_EARLY = SAMPLE_W'(MID_SAMPLE - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_MID   = SAMPLE_W'(MID_SAMPLE);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LATE  = SAMPLE_W'(MID_SAMPLE + 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST  = SAMPLE_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  // True when at least two of the three samples are high.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampled_if
// Byte-side bundle of the UART receiver. It carries the configuration that
// the consumer hands to the receiver and the byte/status results that come
// back.
//
// Signals:
//   rx_en          receiver enable (0 aborts a frame and holds idle)
//   parity_sel     0 = even parity, 1 = odd parity
//   stop_sel       0 = one stop bit, 1 = two stop bits
//   baud_divisor   clk cycles per sample tick (0 behaves as 1)
//   rx_data_out    last received byte
//   rx_valid_out   one-cycle strobe when a frame completes
//   rx_parity_ok   parity result of the last frame
//   rx_frame_err   a stop bit of the last frame was sampled low
//   rx_busy        receiver is inside a frame
//
// Modports:
//   master  the receiver side (drives results, reads configuration)
//   slave   the byte consumer (drives configuration, reads results)
// ---------------------------------------------------------------------------
interface uart_rx_oversampled_if #(
  parameter int DIV_W = 12
);

  logic             rx_en;
  logic             parity_sel;
  logic             stop_sel;
  logic [DIV_W-1:0] baud_divisor;
  logic [7:0]       rx_data_out;
  logic             rx_valid_out;
  logic             rx_parity_ok;
  logic             rx_frame_err;
  logic             rx_busy;

  modport master (
    input  rx_en,
    input  parity_sel,
    input  stop_sel,
    input  baud_divisor,
    output rx_data_out,
    output rx_valid_out,
    output rx_parity_ok,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    output rx_en,
    output parity_sel,
    output stop_sel,
    output baud_divisor,
    input  rx_data_out,
    input  rx_valid_out,
    input  rx_parity_ok,
    input  rx_frame_err,
    input  rx_busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Divides the system clock down to the UART sample-tick rate. The counter
// runs 0 .. max(divisor,1)-1 and raises tick for one cycle on the terminal
// count. A synchronous clear lets the receiver realign the tick phase to a
// detected start edge. The transmitter can reuse the block as-is.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   clear     hold the counter at zero and suppress tick
//   enable    advance the counter
//   divisor   clk cycles per tick; 0 is treated as 1
//   tick      one-cycle pulse at the terminal count
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] terminal;

  // A divisor of 0 would otherwise never match; treat it like 1. In that
  // case the terminal count is 0 and a tick fires on every enabled cycle.
  assign terminal = (divisor == '0) ? '0 : divisor - DIV_W'(1);

  assign tick = enable && !clear && (count == terminal);

  // Free-running divider. It wraps on the tick and is forced to zero while
  // cleared, so that the first tick after a clear comes a full period later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampled
// Oversampling UART receiver for the 8-bit link. A frame is: start bit,
// 8 data bits LSB-first, one parity bit, then 1 or 2 stop bits. The line is
// sampled OVERSAMPLE times per bit. Each bit value is the 2-of-3 majority of
// the samples around the bit centre. Every frame is delivered with a
// one-cycle valid strobe, and parity and framing flags qualify the byte.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   rx_in    asynchronous serial line, idle high
//   bus      uart_rx_oversampled_if.master
//            (configuration in; byte, strobe, flags and busy out)
// ---------------------------------------------------------------------------
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_in,
  uart_rx_oversampled_if.master  bus
);

  logic              sync_1;
  logic              sync_2;
  logic              line_prev;
  logic              start_edge;

  rx_state_t         state;
  rx_state_t         state_next;

  logic              tick;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic [2:0]        bit_idx;
  logic              samp_early;
  logic              samp_mid;
  logic              bit_val;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_lat;
  logic              stop_lat;
  logic              parity_ok_acc;
  logic              frame_err_acc;

  logic              at_decide;
  logic              at_bit_end;
  logic              latch_cfg;
  logic              shift_en;
  logic              parity_cap;
  logic              stop_cap;
  logic              finish;

  // Two-flop synchronizer on the pad input, plus one more delayed copy for
  // edge detection. All three flops reset high, so that leaving reset never
  // looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_1    <= rx_in;
      sync_2    <= sync_1;
      line_prev <= sync_2;
    end
  end

  // Start detection is edge-based. A line held low (break) therefore cannot
  // retrigger frames until it has gone high again.
  assign start_edge = line_prev & ~sync_2;

  // The tick divider is held cleared while idle. This puts the sample phase
  // of every frame relative to its own start edge.
  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .divisor (bus.baud_divisor),
    .tick    (tick)
  );

  assign at_decide  = tick && (sample_cnt == SAMPLE_LATE);
  assign at_bit_end = tick && (sample_cnt == SAMPLE_LAST);

  // The bit value is only used on the late sample tick. At that point the
  // two earlier samples are already stored and the late one is live.
  assign bit_val = majority3(samp_early, samp_mid, sync_2);

  assign bus.rx_busy = (state != IDLE);

  // Frame state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. Bit decisions happen on the late vote
  // sample and state advances happen on the last sample of a bit. The one
  // exception is the final stop bit: the frame finishes right at its vote.
  // This returns the receiver to idle early enough to catch a start edge
  // during the second half of that stop bit. Dropping rx_en overrides
  // everything and abandons the frame without a strobe.
  always_comb begin
    state_next = state;
    latch_cfg  = 1'b0;
    shift_en   = 1'b0;
    parity_cap = 1'b0;
    stop_cap   = 1'b0;
    finish     = 1'b0;
    if (!bus.rx_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state_next = START;
            latch_cfg  = 1'b1;
          end
        end
        START: begin
          if (at_decide && bit_val) begin
            state_next = IDLE;
          end else if (at_bit_end) begin
            state_next = DATA;
          end
        end
        DATA: begin
          if (at_decide) begin
            shift_en = 1'b1;
          end
          if (at_bit_end && (bit_idx == 3'(DATA_W - 1))) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          if (at_decide) begin
            parity_cap = 1'b1;
          end
          if (at_bit_end) begin
            state_next = STOP1;
          end
        end
        STOP1: begin
          if (at_decide) begin
            stop_cap = 1'b1;
            if (!stop_lat) begin
              finish     = 1'b1;
              state_next = IDLE;
            end
          end else if (at_bit_end) begin
            state_next = STOP2;
          end
        end
        STOP2: begin
          if (at_decide) begin
            stop_cap   = 1'b1;
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Frame datapath: sample counter, vote samples, shift register and
  // per-frame accumulators. The output registers change only when a frame
  // finishes, so an aborted frame leaves the last delivered byte visible.
  // The framing flag ORs in the stop-bit vote being taken in the finishing
  // cycle, because that vote has not reached the accumulator yet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt       <= '0;
      bit_idx          <= '0;
      samp_early       <= 1'b1;
      samp_mid         <= 1'b1;
      shift_reg        <= '0;
      parity_lat       <= 1'b0;
      stop_lat         <= 1'b0;
      parity_ok_acc    <= 1'b0;
      frame_err_acc    <= 1'b0;
      bus.rx_data_out  <= '0;
      bus.rx_valid_out <= 1'b0;
      bus.rx_parity_ok <= 1'b0;
      bus.rx_frame_err <= 1'b0;
    end else begin
      bus.rx_valid_out <= finish;

      if (state == IDLE) begin
        sample_cnt    <= '0;
        bit_idx       <= '0;
        frame_err_acc <= 1'b0;
      end else if (tick) begin
        sample_cnt <= sample_cnt + SAMPLE_W'(1);
      end

      if (tick && (sample_cnt == SAMPLE_EARLY)) begin
        samp_early <= sync_2;
      end
      if (tick && (sample_cnt == SAMPLE_MID)) begin
        samp_mid <= sync_2;
      end

      if (latch_cfg) begin
        parity_lat <= bus.parity_sel;
        stop_lat   <= bus.stop_sel;
      end

      if (shift_en) begin
        shift_reg <= {bit_val, shift_reg[DATA_W-1:1]};
      end
      if ((state == DATA) && at_bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (parity_cap) begin
        parity_ok_acc <= (((^shift_reg) ^ bit_val) == parity_lat);
      end
      if (stop_cap && !bit_val) begin
        frame_err_acc <= 1'b1;
      end

      if (finish) begin
        bus.rx_data_out  <= shift_reg;
        bus.rx_parity_ok <= parity_ok_acc;
        bus.rx_frame_err <= frame_err_acc | ~bit_val;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_oversampled
// Self-checking bench for the oversampling UART receiver. The frame driver
// serializes frames onto rx_in with whole-bit timing. For each frame it
// queues the byte, flags and strobe cycle that the receiver must produce.
// These come from the frame rules alone. A single compare process watches
// the receiver on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_oversampled;

  localparam int OS = 16;

  typedef struct {
    logic [7:0] data;
    logic       pok;
    logic       ferr;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic rx_in;

  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   strobe_cnt = 0;
  int   n_expected = 0;

  exp_t       expq[$];
  exp_t       e_chk;
  logic [7:0] held_data;
  logic       held_pok;
  logic       held_ferr;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_oversampled_if #(.DIV_W(12)) bus ();

  uart_rx_oversampled #(.DIV_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_in (rx_in),
    .bus   (bus)
  );

  // Watchdog: all stimulus has a fixed length, so this only trips if
  // simulation stalls.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process. While reset is low, all outputs must be at their reset
  // values. A strobe must match the oldest queued frame and land within
  // two clocks of its expected cycle. Between strobes, the outputs must hold
  // the last delivered values.
  always @(negedge clk) begin
    if (!reset) begin
      held_data = 8'h00;
      held_pok  = 1'b0;
      held_ferr = 1'b0;
      expq.delete();
      check_output("reset_valid", int'(bus.rx_valid_out), 0);
      check_output("reset_data", int'(bus.rx_data_out), 0);
      check_output("reset_busy", int'(bus.rx_busy), 0);
    end else if (bus.rx_valid_out) begin
      strobe_cnt++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe actual=1 required=0 (cycle %0d, data 0x%0h)", cyc, bus.rx_data_out);
      end else begin
        e_chk = expq.pop_front();
        checks++;
        if (cyc < e_chk.due - 2 || cyc > e_chk.due + 2) begin
          errors++;
          $display("[TB] FAIL strobe_cycle actual=%0d required=%0d", cyc, e_chk.due);
        end
        check_output("strobe_data", int'(bus.rx_data_out), int'(e_chk.data));
        check_output("strobe_parity_ok", int'(bus.rx_parity_ok), int'(e_chk.pok));
        check_output("strobe_frame_err", int'(bus.rx_frame_err), int'(e_chk.ferr));
        held_data = e_chk.data;
        held_pok  = e_chk.pok;
        held_ferr = e_chk.ferr;
      end
    end else begin
      if (expq.size() != 0 && cyc > expq[0].due + 2) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed_strobe actual=none required=cycle_%0d (data 0x%0h)", expq[0].due, expq[0].data);
        void'(expq.pop_front());
      end
      check_output("held_data", int'(bus.rx_data_out), int'(held_data));
      check_output("held_parity_ok", int'(bus.rx_parity_ok), int'(held_pok));
      check_output("held_frame_err", int'(bus.rx_frame_err), int'(held_ferr));
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Serialize one frame, starting at the current falling edge.
  // abort_kind: 0 = complete frame, 1 = pulse reset in data bit 4,
  // 2 = drop rx_en in data bit 4. Aborted frames queue no expectation.
  // Parity/stop configuration is scrambled during data bit 2, because the
  // receiver must use the values captured at the start edge.
  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic psel,
                            input logic ssel, input logic s1, input logic s2,
                            input int abort_kind);
    int          lim;
    int          nbits;
    logic [11:0] bits;
    exp_t        e;
    lim   = (bus.baud_divisor == 12'd0) ? 1 : int'(bus.baud_divisor);
    nbits = ssel ? 12 : 11;
    bits  = {s2, s1, pbit, data, 1'b0};
    bus.parity_sel = psel;
    bus.stop_sel   = ssel;
    if (abort_kind == 0) begin
      e.data = data;
      e.pok  = (((^data) ^ pbit) == psel);
      e.ferr = !s1 || (ssel && !s2);
      // Edge -> START takes 3 clk, then (16*bit + 10) ticks until the vote
      // of the last stop bit, and the strobe follows that vote by one clk.
      e.due  = cyc + 3 + (OS * (nbits - 1) + 10) * lim;
      expq.push_back(e);
      n_expected++;
    end
    for (int i = 0; i < nbits; i++) begin
      rx_in = bits[i];
      for (int c = 0; c < OS * lim; c++) begin
        if (i == 3 && c == 0) begin
          bus.parity_sel = 1'($urandom_range(0, 1));
          bus.stop_sel   = 1'($urandom_range(0, 1));
        end
        if (i == 2 && c == 0 && abort_kind == 0) begin
          check_output("busy_mid_frame", int'(bus.rx_busy), 1);
        end
        if (abort_kind != 0 && i == 5 && c == 8 * lim) begin
          if (abort_kind == 1) begin
            #2 reset = 1'b0;
            rx_in = 1'b1;
            repeat (5) @(negedge clk);
            #2 reset = 1'b1;
          end else begin
            bus.rx_en = 1'b0;
            rx_in = 1'b1;
            repeat (5) @(negedge clk);
            bus.rx_en = 1'b1;
          end
          repeat (40) @(negedge clk);
          return;
        end
        @(negedge clk);
      end
    end
    rx_in = 1'b1;
  endtask

  initial begin
    logic [7:0] rdata;
    logic       rpsel;
    logic       rssel;
    logic       rpbit;
    logic       rs1;
    logic       rs2;
    int         base;

    reset            = 1'b0;
    rx_in            = 1'b1;
    bus.rx_en        = 1'b1;
    bus.parity_sel   = 1'b0;
    bus.stop_sel     = 1'b0;
    bus.baud_divisor = 12'd10;
    repeat (4) @(negedge clk);
    check_output("rst_data", int'(bus.rx_data_out), 'h00);
    check_output("rst_valid", int'(bus.rx_valid_out), 0);
    check_output("rst_parity_ok", int'(bus.rx_parity_ok), 0);
    check_output("rst_frame_err", int'(bus.rx_frame_err), 0);
    check_output("rst_busy", int'(bus.rx_busy), 0);
    #2 reset = 1'b1;
    @(negedge clk);
    idle(20);

    $display("[TB] even parity, one stop, 0xA5");
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(20);
    check_output("a5_data", int'(bus.rx_data_out), 'hA5);
    check_output("a5_parity_ok", int'(bus.rx_parity_ok), 1);
    check_output("a5_frame_err", int'(bus.rx_frame_err), 0);
    check_output("a5_strobes", strobe_cnt, 1);

    $display("[TB] odd parity 0x3C, good then bad parity bit");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    idle(20);
    check_output("3c_good_data", int'(bus.rx_data_out), 'h3C);
    check_output("3c_good_parity_ok", int'(bus.rx_parity_ok), 1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    idle(20);
    check_output("3c_bad_data", int'(bus.rx_data_out), 'h3C);
    check_output("3c_bad_parity_ok", int'(bus.rx_parity_ok), 0);

    $display("[TB] two stop bits 0xFF, second stop low then high");
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(30);
    check_output("ff_err_data", int'(bus.rx_data_out), 'hFF);
    check_output("ff_err_parity_ok", int'(bus.rx_parity_ok), 1);
    check_output("ff_err_frame_err", int'(bus.rx_frame_err), 1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    idle(20);
    check_output("ff_ok_frame_err", int'(bus.rx_frame_err), 0);

    $display("[TB] 30 clk low glitch");
    rx_in = 1'b0;
    repeat (30) @(negedge clk);
    rx_in = 1'b1;
    repeat (OS * 10) @(negedge clk);
    check_output("glitch_busy", int'(bus.rx_busy), 0);
    check_output("glitch_strobes", strobe_cnt, 5);

    $display("[TB] back-to-back 0x55, 0xAA");
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(20);
    check_output("b2b_data", int'(bus.rx_data_out), 'hAA);
    check_output("b2b_strobes", strobe_cnt, 7);

    $display("[TB] reset during data bit 4, then 0x81");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    check_output("rst_abort_data", int'(bus.rx_data_out), 'h00);
    check_output("rst_abort_busy", int'(bus.rx_busy), 0);
    base = strobe_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(20);
    check_output("post_rst_data", int'(bus.rx_data_out), 'h81);
    check_output("post_rst_parity_ok", int'(bus.rx_parity_ok), 1);

    $display("[TB] rx_en drop during data bit 4, then 0x81");
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    check_output("en_abort_data", int'(bus.rx_data_out), 'h81);
    check_output("en_abort_strobes", strobe_cnt, base + 1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(20);
    check_output("post_en_data", int'(bus.rx_data_out), 'h81);

    $display("[TB] break after framing error");
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    rx_in = 1'b0;
    base = strobe_cnt;
    repeat (3 * OS * 10) @(negedge clk);
    check_output("break_strobes", strobe_cnt, base);
    check_output("break_frame_err", int'(bus.rx_frame_err), 1);
    idle(40);
    send_frame(8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(20);
    check_output("post_break_data", int'(bus.rx_data_out), 'h42);

    $display("[TB] randomized frames");
    repeat (24) begin
      bus.baud_divisor = 12'($urandom_range(0, 3));
      rdata = 8'($urandom_range(0, 255));
      rpsel = 1'($urandom_range(0, 1));
      rssel = 1'($urandom_range(0, 1));
      rpbit = 1'($urandom_range(0, 1));
      rs1   = ($urandom_range(0, 7) != 0);
      rs2   = ($urandom_range(0, 7) != 0);
      send_frame(rdata, rpbit, rpsel, rssel, rs1, rs2, 0);
      if (!(rssel ? rs2 : rs1)) begin
        idle(20);
      end else begin
        idle($urandom_range(0, 20));
      end
    end

    idle(200);
    check_output("queue_drained", expq.size(), 0);
    check_output("total_strobes", strobe_cnt, n_expected);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
